video_timing_generator: RTL and testbench

Parametrised successor to the fixed-format sync generator. Produces h/v sync, display-enable, active-area pixel coordinates and line/frame start strobes from one pixel clock. Includes a clock enable so it can run from a divided pixel rate. Sits between the pixel clock source and the character/pixel fetch pipeline, and drives the VGA connector's sync pins.

---
 rtl/video_timing_generator.sv | 143 ++++++++++++++
 tb/tb_video_timing_generator.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_generator.sv
// Video timing generator: h/v sync, display enable, active coordinates and
// line/frame start strobes from a single pixel clock with a clock enable.
// Every output is derived from the next position and registered with it, so
// all outputs describe the same pixel in the same cycle.
// Optional feature: define VTC_FRAME_COUNT_EN to add a 16-bit frame counter.
module video_timing_generator #(
   parameter int unsigned CW       = 12,
   parameter int unsigned H_ACTIVE = 800,
   parameter int unsigned H_FP     = 40,
   parameter int unsigned H_SYNC   = 128,
   parameter int unsigned H_BP     = 88,
   parameter int unsigned V_ACTIVE = 600,
   parameter int unsigned V_FP     = 1,
   parameter int unsigned V_SYNC   = 4,
   parameter int unsigned V_BP     = 23,
   parameter logic        H_POL    = 1'b1,
   parameter logic        V_POL    = 1'b1
) (
   input  logic          pixel_clk,
   input  logic          reset_n,
   input  logic          ce,
   output logic          h_sync,
   output logic          v_sync,
   output logic          de,
   output logic [CW-1:0] h_pos,
   output logic [CW-1:0] v_pos,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output logic          line_start,
`ifdef VTC_FRAME_COUNT_EN
   output logic [15:0]   frame_cnt,
`endif
   output logic          frame_start
);

   localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CW-1:0] HLast      = CW'(HTotal - 1);
   localparam logic [CW-1:0] VLast      = CW'(VTotal - 1);
   localparam logic [CW-1:0] HAct       = CW'(H_ACTIVE);
   localparam logic [CW-1:0] VAct       = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HSyncStart = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HSyncEnd   = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0] VSyncStart = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VSyncEnd   = CW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CW-1:0] One        = CW'(1);

   logic [CW-1:0] h_q, h_d, v_q, v_d, x_q, x_d, y_q, y_d;
   logic          hs_q, hs_d, vs_q, vs_d, de_q, de_d, ls_q, ls_d, fs_q, fs_d;
   logic [CW-1:0] h_nxt, v_nxt;
   logic          de_nxt;

   // Position after one pixel advance (used only when ce is high).
   always_comb begin
      h_nxt = h_q + One;
      v_nxt = v_q;
      if (h_q == HLast) begin
         h_nxt = '0;
         v_nxt = (v_q == VLast) ? '0 : (v_q + One);
      end
   end

   // Next-state: hold everything on ce=0 except the strobes, which clear.
   always_comb begin
      h_d    = h_q;
      v_d    = v_q;
      hs_d   = hs_q;
      vs_d   = vs_q;
      de_d   = de_q;
      x_d    = x_q;
      y_d    = y_q;
      ls_d   = 1'b0;
      fs_d   = 1'b0;
      de_nxt = (h_nxt < HAct) && (v_nxt < VAct);
      if (ce) begin
         h_d  = h_nxt;
         v_d  = v_nxt;
         hs_d = ((h_nxt >= HSyncStart) && (h_nxt < HSyncEnd)) ? H_POL : ~H_POL;
         // v_nxt only moves when h wraps, so v_sync only changes at h_pos==0.
         vs_d = ((v_nxt >= VSyncStart) && (v_nxt < VSyncEnd)) ? V_POL : ~V_POL;
         de_d = de_nxt;
         x_d  = de_nxt ? h_nxt : '0;
         y_d  = (v_nxt < VAct) ? v_nxt : '0;
         ls_d = (h_nxt == '0);
         fs_d = (h_nxt == '0) && (v_nxt == '0);
      end
   end

   // Timing state; reset parks on the last pixel so the first advance is (0,0).
   always_ff @(posedge pixel_clk or negedge reset_n) begin
      if (!reset_n) begin
         h_q  <= HLast;
         v_q  <= VLast;
         hs_q <= ~H_POL;
         vs_q <= ~V_POL;
         de_q <= 1'b0;
         x_q  <= '0;
         y_q  <= '0;
         ls_q <= 1'b0;
         fs_q <= 1'b0;
      end else begin
         h_q  <= h_d;
         v_q  <= v_d;
         hs_q <= hs_d;
         vs_q <= vs_d;
         de_q <= de_d;
         x_q  <= x_d;
         y_q  <= y_d;
         ls_q <= ls_d;
         fs_q <= fs_d;
      end
   end

`ifdef VTC_FRAME_COUNT_EN
   logic [15:0] frame_cnt_q, frame_cnt_d;

   // Count frames in the same edge that raises frame_start.
   always_comb begin
      frame_cnt_d = frame_cnt_q;
      if (fs_d) frame_cnt_d = frame_cnt_q + 16'd1;
   end

   // Frame counter register.
   always_ff @(posedge pixel_clk or negedge reset_n) begin
      if (!reset_n) frame_cnt_q <= 16'd0;
      else          frame_cnt_q <= frame_cnt_d;
   end

   assign frame_cnt = frame_cnt_q;
`endif

   assign h_pos       = h_q;
   assign v_pos       = v_q;
   assign h_sync      = hs_q;
   assign v_sync      = vs_q;
   assign de          = de_q;
   assign x           = x_q;
   assign y           = y_q;
   assign line_start  = ls_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_video_timing_generator.sv
// Bench for video_timing_generator: a default-timing instance checked over two
// lines, and a tiny active-low-sync instance (8x6 total) checked by a vector
// table, over full frames, and across a mid-frame asynchronous reset.
module tb_video_timing_generator;

   localparam int unsigned CW = 12;

   logic clk = 1'b0;
   logic ce = 1'b0;
   logic rst_d = 1'b0;
   logic rst_s = 1'b0;

   always #5 clk = ~clk;

   // Default-parameter instance.
   logic          d_hs, d_vs, d_de, d_ls, d_fs;
   logic [CW-1:0] d_h, d_v, d_x, d_y;
`ifdef VTC_FRAME_COUNT_EN
   logic [15:0]   d_fc;
`endif

   video_timing_generator u_dut_d (
      .pixel_clk   (clk),
      .reset_n     (rst_d),
      .ce          (ce),
      .h_sync      (d_hs),
      .v_sync      (d_vs),
      .de          (d_de),
      .h_pos       (d_h),
      .v_pos       (d_v),
      .x           (d_x),
      .y           (d_y),
      .line_start  (d_ls),
`ifdef VTC_FRAME_COUNT_EN
      .frame_cnt   (d_fc),
`endif
      .frame_start (d_fs)
   );

   // Tiny instance: H 4/1/2/1 (total 8), V 3/1/1/1 (total 6), active-low syncs.
   logic          s_hs, s_vs, s_de, s_ls, s_fs;
   logic [CW-1:0] s_h, s_v, s_x, s_y;
`ifdef VTC_FRAME_COUNT_EN
   logic [15:0]   s_fc;
`endif

   video_timing_generator #(
      .CW       (CW),
      .H_ACTIVE (4),
      .H_FP     (1),
      .H_SYNC   (2),
      .H_BP     (1),
      .V_ACTIVE (3),
      .V_FP     (1),
      .V_SYNC   (1),
      .V_BP     (1),
      .H_POL    (1'b0),
      .V_POL    (1'b0)
   ) u_dut_s (
      .pixel_clk   (clk),
      .reset_n     (rst_s),
      .ce          (ce),
      .h_sync      (s_hs),
      .v_sync      (s_vs),
      .de          (s_de),
      .h_pos       (s_h),
      .v_pos       (s_v),
      .x           (s_x),
      .y           (s_y),
      .line_start  (s_ls),
`ifdef VTC_FRAME_COUNT_EN
      .frame_cnt   (s_fc),
`endif
      .frame_start (s_fs)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Drive ce at the falling edge, then sample 1 ns after the rising edge.
   task automatic step(input logic c);
      @(negedge clk);
      ce = c;
      @(posedge clk);
      #1;
   endtask

   // Full expected-output check of the tiny instance at model position (h,v).
   task automatic chk_s(input string tag, input int h, input int v);
      logic e_de;
      e_de = (h < 4) && (v < 3);
      chk({tag, " h_pos"},  32'(s_h), 32'(h));
      chk({tag, " v_pos"},  32'(s_v), 32'(v));
      chk({tag, " h_sync"}, 32'(s_hs), 32'((h >= 5 && h < 7) ? 0 : 1));
      chk({tag, " v_sync"}, 32'(s_vs), 32'((v == 4) ? 0 : 1));
      chk({tag, " de"},     32'(s_de), 32'(e_de));
      chk({tag, " x"},      32'(s_x),  32'(e_de ? h : 0));
      chk({tag, " y"},      32'(s_y),  32'((v < 3) ? v : 0));
   endtask

   typedef struct {
      logic ce;
      int   h;
      int   v;
      logic de;
      logic hs;
      logic vs;
      logic ls;
      logic fs;
      int   x;
      int   y;
   } vec_t;

   vec_t tbl[13];

   initial begin
      int eh, ev, last_ls, last_fs, cyc, n_ls_d;

      //        ce    h  v  de    hs    vs    ls    fs    x  y
      tbl[0]  = '{1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0};
      tbl[1]  = '{1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0};
      tbl[2]  = '{1'b1, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0};
      tbl[3]  = '{1'b0, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0};
      tbl[4]  = '{1'b1, 2, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2, 0};
      tbl[5]  = '{1'b1, 3, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3, 0};
      tbl[6]  = '{1'b1, 4, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0};
      tbl[7]  = '{1'b1, 5, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0};
      tbl[8]  = '{1'b1, 6, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0};
      tbl[9]  = '{1'b0, 6, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0};
      tbl[10] = '{1'b1, 7, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0};
      tbl[11] = '{1'b1, 0, 1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1};
      tbl[12] = '{1'b1, 1, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1};

      // ---- Default instance: reset values, first edge, two lines ----
      #12;
      chk("d rst h_pos", 32'(d_h), 32'd1055);
      chk("d rst v_pos", 32'(d_v), 32'd627);
      chk("d rst h_sync", 32'(d_hs), 32'd0);
      chk("d rst v_sync", 32'(d_vs), 32'd0);
      chk("d rst de", 32'(d_de), 32'd0);
      chk("d rst strobes", 32'({d_ls, d_fs}), 32'd0);
      @(negedge clk);
      rst_d = 1'b1;
      step(1'b1);
      chk("d first h_pos", 32'(d_h), 32'd0);
      chk("d first v_pos", 32'(d_v), 32'd0);
      chk("d first fs", 32'(d_fs), 32'd1);
      chk("d first ls", 32'(d_ls), 32'd1);
      chk("d first de", 32'(d_de), 32'd1);
      chk("d first syncs", 32'({d_hs, d_vs}), 32'd0);
      eh = 0;
      ev = 0;
      last_ls = 0;
      n_ls_d = 0;
      for (int i = 1; i <= 2 * 1056; i++) begin
         step(1'b1);
         eh = (eh == 1055) ? 0 : eh + 1;
         if (eh == 0) ev = ev + 1;
         chk("d h_pos", 32'(d_h), 32'(eh));
         chk("d v_pos", 32'(d_v), 32'(ev));
         chk("d h_sync", 32'(d_hs), 32'((eh >= 840 && eh < 968) ? 1 : 0));
         chk("d de", 32'(d_de), 32'(eh < 800));
         chk("d x", 32'(d_x), 32'((eh < 800) ? eh : 0));
         chk("d ls", 32'(d_ls), 32'(eh == 0));
         if (d_ls) begin
            chk("d line period", 32'(i - last_ls), 32'd1056);
            last_ls = i;
            n_ls_d++;
         end
      end
      chk("d line count", 32'(n_ls_d), 32'd2);

      // ---- Tiny instance: reset values then vector table ----
      @(negedge clk);
      ce = 1'b0;
      chk_s("s rst", 7, 5);
      chk("s rst strobes", 32'({s_ls, s_fs}), 32'd0);
      rst_s = 1'b1;
      for (int i = 0; i < 13; i++) begin
         step(tbl[i].ce);
         chk($sformatf("vec%0d h_pos", i), 32'(s_h), 32'(tbl[i].h));
         chk($sformatf("vec%0d v_pos", i), 32'(s_v), 32'(tbl[i].v));
         chk($sformatf("vec%0d de", i), 32'(s_de), 32'(tbl[i].de));
         chk($sformatf("vec%0d h_sync", i), 32'(s_hs), 32'(tbl[i].hs));
         chk($sformatf("vec%0d v_sync", i), 32'(s_vs), 32'(tbl[i].vs));
         chk($sformatf("vec%0d ls", i), 32'(s_ls), 32'(tbl[i].ls));
         chk($sformatf("vec%0d fs", i), 32'(s_fs), 32'(tbl[i].fs));
         chk($sformatf("vec%0d x", i), 32'(s_x), 32'(tbl[i].x));
         chk($sformatf("vec%0d y", i), 32'(s_y), 32'(tbl[i].y));
      end

      // ---- Tiny instance: two-plus frames against the model ----
      eh = 1;
      ev = 1;
      last_ls = 0;
      last_fs = -1;
      for (cyc = 1; cyc <= 110; cyc++) begin
         step(1'b1);
         if (eh == 7) begin
            eh = 0;
            ev = (ev == 5) ? 0 : ev + 1;
         end else begin
            eh = eh + 1;
         end
         chk_s("s run", eh, ev);
         chk("s run ls", 32'(s_ls), 32'(eh == 0));
         chk("s run fs", 32'(s_fs), 32'(eh == 0 && ev == 0));
         if (s_ls) begin
            if (last_ls != 0) chk("s line period", 32'(cyc - last_ls), 32'd8);
            last_ls = cyc;
         end
         if (s_fs) begin
            if (last_fs >= 0) chk("s frame period", 32'(cyc - last_fs), 32'd48);
            last_fs = cyc;
         end
      end

      // ---- Tiny instance: async reset mid-frame, then restart ----
      for (int i = 0; i < 48 && !(eh == 2 && ev == 2); i++) begin
         step(1'b1);
         if (eh == 7) begin
            eh = 0;
            ev = (ev == 5) ? 0 : ev + 1;
         end else begin
            eh = eh + 1;
         end
      end
      chk("s pre-reset pos", 32'({s_v, s_h}), 32'({12'd2, 12'd2}));
      #2;
      rst_s = 1'b0;
      #1;
      chk_s("s midrst", 7, 5);
      chk("s midrst strobes", 32'({s_ls, s_fs}), 32'd0);
`ifdef VTC_FRAME_COUNT_EN
      chk("s midrst frame_cnt", 32'(s_fc), 32'd0);
`endif
      @(negedge clk);
      rst_s = 1'b1;
      ce = 1'b1;
      @(posedge clk);
      #1;
      chk_s("s restart", 0, 0);
      chk("s restart fs", 32'(s_fs), 32'd1);
      chk("s restart ls", 32'(s_ls), 32'd1);
`ifdef VTC_FRAME_COUNT_EN
      chk("s restart frame_cnt", 32'(s_fc), 32'd1);
`endif
      step(1'b0);
      chk("s strobe one clock", 32'({s_ls, s_fs}), 32'd0);
      chk("s hold on ce=0", 32'(s_h), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
